// File: rtl/addr_manager_v0_1.sv
// Linked-list address manager for a shared packet buffer.
// Keeps a next-pointer table plus a free list; writers pop the head, readers push to the tail.
//
// Ports:
//   clk, rstn              clock and asynchronous active-low reset
//   s_axis_wr_en           allocate the slot at m_axis_fl_head
//   s_axis_rd_en           release the current read slot and follow its link
//   s_axis_first_word_en   load s_axis_rd_addr as the start of a read chain
//   s_axis_rd_addr         start-of-packet address
//   m_axis_fl_head         next address to be allocated
//   m_axis_rd_next_addr    next address to be read and released
//   m_axis_remain_space    number of free slots
//   m_axis_almost_full     free slots <= ALMOST_FULL_THRESH
//   m_axis_is_empty        no slot allocated
module addr_manager_v0_1 #(
  parameter int ADDR_TABLE_DEPTH   = 1024,
  parameter int ADDR_WIDTH         = 12,
  parameter int ALMOST_FULL_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_axis_wr_en,
  input  logic                  s_axis_rd_en,
  input  logic                  s_axis_first_word_en,
  input  logic [ADDR_WIDTH-1:0] s_axis_rd_addr,
  output logic [ADDR_WIDTH-1:0] m_axis_fl_head,
  output logic [ADDR_WIDTH-1:0] m_axis_rd_next_addr,
  output logic [ADDR_WIDTH-1:0] m_axis_remain_space,
  output logic                  m_axis_almost_full,
  output logic                  m_axis_is_empty
);

  localparam int AW = ADDR_WIDTH;
  localparam int D  = ADDR_TABLE_DEPTH;
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  localparam logic [AW-1:0] DEPTH_W = AW'(D);
  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic [AW-1:0] AF_TH   = AW'(ALMOST_FULL_THRESH);

  logic [AW-1:0] next_q [D];

  logic [AW-1:0] fl_head_q, fl_head_d;
  logic [IW-1:0] fl_tail_q, fl_tail_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] remain_q, remain_d;

  logic          wr_ok;
  logic          rd_ok;
  logic [AW-1:0] cur;
  logic [IW-1:0] head_ix;
  logic [IW-1:0] cur_ix;

  assign wr_ok   = s_axis_wr_en && (remain_q != '0);
  assign rd_ok   = s_axis_rd_en && (remain_q != DEPTH_W);
  assign cur     = s_axis_first_word_en ? s_axis_rd_addr : rd_ptr_q;
  assign head_ix = fl_head_q[IW-1:0];
  assign cur_ix  = cur[IW-1:0];

  always_comb begin
    fl_head_d = fl_head_q;
    fl_tail_d = fl_tail_q;
    rd_ptr_d  = rd_ptr_q;
    remain_d  = remain_q;

    if (s_axis_first_word_en)
      rd_ptr_d = s_axis_rd_addr;

    if (wr_ok)
      fl_head_d = next_q[head_ix];

    if (rd_ok) begin
      fl_tail_d = cur_ix;
      rd_ptr_d  = next_q[cur_ix];
      // The freed slot must become the head when the list is empty,
      // or when its single entry is being allocated in this same cycle.
      if (remain_q == '0 || (remain_q == ONE && wr_ok))
        fl_head_d = cur;
    end

    unique case (1'b1)
      wr_ok && !rd_ok: remain_d = remain_q - ONE;
      rd_ok && !wr_ok: remain_d = remain_q + ONE;
      default:         remain_d = remain_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < D; i++)
        next_q[i] <= (i == D - 1) ? AW'(D - 1) : AW'(i + 1);
    end else if (rd_ok) begin
      next_q[fl_tail_q] <= cur;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fl_head_q <= '0;
      fl_tail_q <= IW'(D - 1);
      rd_ptr_q  <= '0;
      remain_q  <= DEPTH_W;
    end else begin
      fl_head_q <= fl_head_d;
      fl_tail_q <= fl_tail_d;
      rd_ptr_q  <= rd_ptr_d;
      remain_q  <= remain_d;
    end
  end

  assign m_axis_fl_head      = fl_head_q;
  assign m_axis_rd_next_addr = rd_ptr_q;
  assign m_axis_remain_space = remain_q;
  assign m_axis_almost_full  = (remain_q <= AF_TH);
  assign m_axis_is_empty     = (remain_q == DEPTH_W);

endmodule

// File: tb/tb_addr_manager_v0_1.sv
// Bench for addr_manager_v0_1: directed scenarios plus random traffic
// checked against a free-queue / packet-queue reference model.
module tb_addr_manager_v0_1;

  localparam int D  = 49;
  localparam int AW = 8;
  localparam int TH = 4;

  logic          clk;
  logic          rstn;
  logic          wr_en;
  logic          rd_en;
  logic          fw_en;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] fl_head;
  logic [AW-1:0] rd_next;
  logic [AW-1:0] remain;
  logic          af;
  logic          empty;

  int n_chk;
  int n_fail;

  addr_manager_v0_1 #(
    .ADDR_TABLE_DEPTH  (D),
    .ADDR_WIDTH        (AW),
    .ALMOST_FULL_THRESH(TH)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .s_axis_wr_en        (wr_en),
    .s_axis_rd_en        (rd_en),
    .s_axis_first_word_en(fw_en),
    .s_axis_rd_addr      (rd_addr),
    .m_axis_fl_head      (fl_head),
    .m_axis_rd_next_addr (rd_next),
    .m_axis_remain_space (remain),
    .m_axis_almost_full  (af),
    .m_axis_is_empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic w, input logic r,
                      input logic f, input logic [AW-1:0] a);
    wr_en   = w;
    rd_en   = r;
    fw_en   = f;
    rd_addr = a;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    fw_en = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_head"},   32'(fl_head), 0);
    chk({tag, "_rdnext"}, 32'(rd_next), 0);
    chk({tag, "_remain"}, 32'(remain),  D);
    chk({tag, "_af"},     32'(af),      0);
    chk({tag, "_empty"},  32'(empty),   1);
  endtask

  // reference model state
  int freeq[$];
  int wordq[$];
  int lenq[$];
  int openq[$];
  int open_target;
  int rd_left;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    fw_en   = 1'b0;
    rd_addr = '0;
    rstn    = 1'b0;
    #2;
    do_reset();
    chk_reset_vals("reset");

    // read with nothing allocated is ignored
    tick(0, 1, 0, 0);
    chk("rd_idle_remain", 32'(remain),  D);
    chk("rd_idle_head",   32'(fl_head), 0);

    // write 3 words, then 2 more
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    chk("wr3_head",   32'(fl_head), 3);
    chk("wr3_remain", 32'(remain),  D - 3);
    chk("wr3_empty",  32'(empty),   0);
    for (int i = 0; i < 2; i++) tick(1, 0, 0, 0);
    chk("wr5_head",   32'(fl_head), 5);
    chk("wr5_remain", 32'(remain),  D - 5);

    // read the 2-word packet starting at 3
    tick(0, 0, 1, 3);
    chk("pkt_start", 32'(rd_next), 3);
    tick(0, 1, 0, 0);
    chk("pkt_rd1", 32'(rd_next), 4);
    chk("pkt_rd1_remain", 32'(remain), D - 4);
    tick(0, 1, 0, 0);
    chk("pkt_rd2_remain", 32'(remain), D - 3);
    chk("pkt_rd2_head",   32'(fl_head), 5);

    // concurrent traffic: read packet at 0 while writing
    tick(0, 0, 1, 0);
    chk("cc_start", 32'(rd_next), 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 0);
      chk("cc_rdnext", 32'(rd_next), i + 1);
      chk("cc_remain", 32'(remain),  D - 3);
    end
    chk("cc_head", 32'(fl_head), 8);

    // exhaustion from reset, checking the almost-full boundary each step
    do_reset();
    chk_reset_vals("reset2");
    for (int k = 1; k <= D; k++) begin
      tick(1, 0, 0, 0);
      chk("exh_remain", 32'(remain), D - k);
      chk("exh_af",     32'(af), ((D - k) <= TH) ? 1 : 0);
      if (k < D) chk("exh_head", 32'(fl_head), k);
    end
    chk("exh_head_last", 32'(fl_head), D - 1);
    tick(1, 0, 0, 0);
    chk("full_wr_remain", 32'(remain),  0);
    chk("full_wr_head",   32'(fl_head), D - 1);

    // free slot 10 from a full buffer: it becomes the head
    tick(0, 1, 1, 10);
    chk("refill_remain", 32'(remain),  1);
    chk("refill_head",   32'(fl_head), 10);
    chk("refill_rdnext", 32'(rd_next), 11);
    // write and read with one free slot: freed slot 11 is forwarded
    tick(1, 1, 0, 0);
    chk("fwd_head",   32'(fl_head), 11);
    chk("fwd_remain", 32'(remain),  1);

    // asynchronous reset mid-operation
    tick(1, 0, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // random traffic against the queue model
    do_reset();
    freeq.delete();
    wordq.delete();
    lenq.delete();
    openq.delete();
    for (int i = 0; i < D; i++) freeq.push_back(i);
    open_target = $urandom_range(6, 1);
    rd_left = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic w, r, f;
      logic [AW-1:0] a;
      bit heavy_wr;
      bit chk_rd;
      int exp_rd;
      int c;
      heavy_wr = ((cyc / 150) % 2) == 0;
      w = ($urandom_range(99) < (heavy_wr ? 85 : 25));
      r = 1'b0;
      f = 1'b0;
      a = AW'($urandom_range(D - 1));
      chk_rd = 0;
      exp_rd = 0;
      if (rd_left == 0 && lenq.size() > 0 && $urandom_range(3) != 0) begin
        rd_left = lenq.pop_front();
        f = 1'b1;
        a = AW'(wordq[0]);
        r = 1'($urandom_range(1));
      end else if (rd_left > 0) begin
        r = ($urandom_range(99) < (heavy_wr ? 30 : 85));
      end

      if (w && freeq.size() > 0) openq.push_back(freeq.pop_front());
      if (r) begin
        c = wordq.pop_front();
        freeq.push_back(c);
        rd_left--;
        if (rd_left > 0) begin
          chk_rd = 1;
          exp_rd = wordq[0];
        end
      end else if (f) begin
        chk_rd = 1;
        exp_rd = wordq[0];
      end
      if (openq.size() >= open_target) begin
        lenq.push_back(openq.size());
        while (openq.size() > 0) wordq.push_back(openq.pop_front());
        open_target = $urandom_range(6, 1);
      end

      tick(w, r, f, a);
      chk("rnd_remain", 32'(remain), freeq.size());
      chk("rnd_af",     32'(af), (freeq.size() <= TH) ? 1 : 0);
      chk("rnd_empty",  32'(empty), (freeq.size() == D) ? 1 : 0);
      if (freeq.size() > 0) chk("rnd_head", 32'(fl_head), freeq[0]);
      if (chk_rd) chk("rnd_rdnext", 32'(rd_next), exp_rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
